icache: RTL

ICACHE -- requirements
Module: icache

---
 rtl/icache_if.sv | 25 ++
 rtl/icache.sv | 129 ++++++++++++
 2 files changed

// File: rtl/icache_if.sv
// Fetch-unit and memory-controller signal bundle for the instruction cache.
// The cache attaches as slave; the fetch unit / controller side as master.
interface icache_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int BLOCK_WIDTH = 1
);
  logic                          IF2IC_en;
  logic [ADDR_WIDTH-1:0]         IF2IC_addr;
  logic                          IC2IF_en;
  logic [31:0]                   IC2IF_inst;
  logic                          IC2MC_en;
  logic [ADDR_WIDTH-1:0]         IC2MC_addr;
  logic [(32<<BLOCK_WIDTH)-1:0]  MC2IC_block;
  logic                          MC2IC_en;

  modport slave (
    input  IF2IC_en, IF2IC_addr, MC2IC_block, MC2IC_en,
    output IC2IF_en, IC2IF_inst, IC2MC_en, IC2MC_addr
  );

  modport master (
    output IF2IC_en, IF2IC_addr, MC2IC_block, MC2IC_en,
    input  IC2IF_en, IC2IF_inst, IC2MC_en, IC2MC_addr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache, one outstanding line fill.
// A redirect during a fill lets the fill land but drops its result.
module icache #(
  parameter int BLOCK_WIDTH = 1,
  parameter int CACHE_SIZE  = 8,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic     clk_in,
  input  logic     rst_in,
  input  logic     rdy_in,
  input  logic     clear,
  icache_if.slave  bus
);
  localparam int OFF   = BLOCK_WIDTH + 2;
  localparam int TAG_W = ADDR_WIDTH - CACHE_SIZE - OFF;
  localparam int LINES = 1 << CACHE_SIZE;
  localparam int WORDS = 1 << BLOCK_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_e;
  typedef logic [WORDS-1:0][31:0] line_t;

  state_e                state_q, state_d;
  logic [LINES-1:0]      valid_q;
  logic [TAG_W-1:0]      tag_q [LINES];
  line_t                 data_q [LINES];
  logic                  en_q, en_d;
  logic [31:0]           inst_q, inst_d;
  logic                  mc_en_q, mc_en_d;
  logic [ADDR_WIDTH-1:0] mc_addr_q, mc_addr_d;
  logic [ADDR_WIDTH-1:0] req_q, req_d;
  logic                  fill_we;

  logic [CACHE_SIZE-1:0]  idx, req_idx;
  logic [TAG_W-1:0]       tag, req_tag;
  logic [BLOCK_WIDTH-1:0] wsel, req_wsel;
  logic                   hit;
  line_t                  fill_line;
  logic                   unused_bits;

  assign idx       = bus.IF2IC_addr[OFF +: CACHE_SIZE];
  assign tag       = bus.IF2IC_addr[ADDR_WIDTH-1 -: TAG_W];
  assign wsel      = bus.IF2IC_addr[2 +: BLOCK_WIDTH];
  assign req_idx   = req_q[OFF +: CACHE_SIZE];
  assign req_tag   = req_q[ADDR_WIDTH-1 -: TAG_W];
  assign req_wsel  = req_q[2 +: BLOCK_WIDTH];
  assign fill_line = bus.MC2IC_block;
  assign hit       = valid_q[idx] && (tag_q[idx] == tag);
  assign unused_bits = ^{bus.IF2IC_addr[1:0], req_q[1:0]};

  assign bus.IC2IF_en   = en_q;
  assign bus.IC2IF_inst = inst_q;
  assign bus.IC2MC_en   = mc_en_q;
  assign bus.IC2MC_addr = mc_addr_q;

  always_comb begin
    state_d   = state_q;
    en_d      = 1'b0;
    inst_d    = inst_q;
    mc_en_d   = mc_en_q;
    mc_addr_d = mc_addr_q;
    req_d     = req_q;
    fill_we   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.IF2IC_en && !en_q && !clear) begin
          if (hit) begin
            en_d   = 1'b1;
            inst_d = data_q[idx][wsel];
          end else begin
            mc_en_d   = 1'b1;
            mc_addr_d = {bus.IF2IC_addr[ADDR_WIDTH-1:OFF],
                         {OFF{1'b0}}};
            req_d     = bus.IF2IC_addr;
            state_d   = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (bus.MC2IC_en) begin
          fill_we = 1'b1;
          mc_en_d = 1'b0;
          state_d = S_IDLE;
          if (!clear) begin
            en_d   = 1'b1;
            inst_d = fill_line[req_wsel];
          end
        end else if (clear) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (bus.MC2IC_en) begin
          fill_we = 1'b1;
          mc_en_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= S_IDLE;
      valid_q   <= '0;
      en_q      <= 1'b0;
      inst_q    <= '0;
      mc_en_q   <= 1'b0;
      mc_addr_q <= '0;
      req_q     <= '0;
    end else if (rdy_in) begin
      state_q   <= state_d;
      en_q      <= en_d;
      inst_q    <= inst_d;
      mc_en_q   <= mc_en_d;
      mc_addr_q <= mc_addr_d;
      req_q     <= req_d;
      if (fill_we) valid_q[req_idx] <= 1'b1;
    end
  end

  // Tag/data need no reset: the valid bits gate every lookup.
  always_ff @(posedge clk_in) begin
    if (rdy_in && fill_we) begin
      tag_q[req_idx]  <= req_tag;
      data_q[req_idx] <= fill_line;
    end
  end
endmodule
